// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame geometry.
// Pure declarations, no logic; the transmitter's frame counter also uses FRAME_BITS.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; both flops reset to idle-high.
// Latency 2 clocks; no backpressure.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with internal bit timer; one-cycle rx_valid / frame_err strobes.
// Latency 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks from start edge; no backpressure.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Timer holds remaining cycles minus one, so an N-cycle wait loads N-1 and fires at zero.
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);

  logic                 rxs;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 tick;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rx),
    .dout (rxs)
  );

  assign tick = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          timer_d = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else if (rxs) begin
          state_d = IDLE;
        end else begin
          timer_d = BIT_LOAD;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else begin
          shift_d[idx_q] = rxs;
          timer_d        = BIT_LOAD;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else if (rxs) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        // Hold here until the line recovers so a long low produces a single error.
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
// Event times are recorded as the edge index E+n at which a level is first observed.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_receiver #(.CLKS_PER_BIT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         vld_t[$];
  logic [7:0] vld_d[$];
  int         err_t[$];
  int         rise_t[$];
  int         fall_t[$];
  int         both = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      vld_t.push_back(cyc + 1);
      vld_d.push_back(rx_data);
    end
    if (frame_err) err_t.push_back(cyc + 1);
    if (rx_valid && frame_err) both <= both + 1;
    if (busy && !busy_prev) rise_t.push_back(cyc + 1);
    if (!busy && busy_prev) fall_t.push_back(cyc + 1);
    busy_prev <= busy;
  end

  int n_vec = 0;
  int n_bad = 0;
  int e_cyc = 0;
  int e1    = 0;
  int dur[10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    vld_t.delete();
    vld_d.delete();
    err_t.delete();
    rise_t.delete();
    fall_t.delete();
  endtask

  // Called 1 time unit after an edge; the next edge is E (first edge seeing rx low).
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits  = {stop_bit, d, 1'b0};
    e_cyc = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      step(dur[k]);
    end
    rx = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 10; k++) dur[k] = 16;

    rst = 1'b1;
    step(2);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    step(3);

    clear_q();
    send_frame(8'h55, 1'b1);
    step(5);
    chk("f55_count", vld_t.size(), 1);
    chk("f55_time", vld_t[0], e_cyc + 155);
    chk("f55_data", vld_d[0], 8'h55);
    chk("f55_no_err", err_t.size(), 0);
    chk("f55_busy_rise", rise_t[0], e_cyc + 3);
    chk("f55_busy_fall", fall_t[0], e_cyc + 155);

    clear_q();
    send_frame(8'hA3, 1'b1);
    e1 = e_cyc;
    send_frame(8'h0F, 1'b1);
    step(5);
    chk("b2b_count", vld_t.size(), 2);
    chk("b2b_first_time", vld_t[0], e1 + 155);
    chk("b2b_spacing", vld_t[1] - vld_t[0], 160);
    chk("b2b_data0", vld_d[0], 8'hA3);
    chk("b2b_data1", vld_d[1], 8'h0F);

    clear_q();
    rx = 1'b0;
    e1 = cyc + 1;
    step(4);
    rx = 1'b1;
    step(20);
    chk("glitch_no_valid", vld_t.size(), 0);
    chk("glitch_no_err", err_t.size(), 0);
    chk("glitch_busy_rise", rise_t[0], e1 + 3);
    chk("glitch_busy_fall", fall_t[0], e1 + 11);
    clear_q();
    send_frame(8'h3C, 1'b1);
    step(5);
    chk("after_glitch_count", vld_t.size(), 1);
    chk("after_glitch_data", vld_d[0], 8'h3C);

    clear_q();
    dur[9] = 40;
    send_frame(8'h81, 1'b0);
    dur[9] = 16;
    step(20);
    chk("ferr_count", err_t.size(), 1);
    chk("ferr_time", err_t[0], e_cyc + 155);
    chk("ferr_no_valid", vld_t.size(), 0);
    chk("ferr_data_held", rx_data, 8'h3C);
    chk("ferr_busy_fall", fall_t[0], e_cyc + 187);

    clear_q();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        step(70);
        rst = 1'b1;
        step(1);
        chk("midrst_rx_data", rx_data, 8'h00);
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
      end
    join
    step(20);
    chk("midrst_no_valid", vld_t.size(), 0);
    chk("midrst_no_err", err_t.size(), 0);
    clear_q();
    send_frame(8'h12, 1'b1);
    step(5);
    chk("after_rst_count", vld_t.size(), 1);
    chk("after_rst_data", vld_d[0], 8'h12);

    for (int k = 0; k < 10; k++) dur[k] = (k % 2 == 0) ? 13 : 19;
    clear_q();
    send_frame(8'h6B, 1'b1);
    step(5);
    chk("skew_early_data", vld_d[0], 8'h6B);
    chk("skew_early_time", vld_t[0], e_cyc + 155);

    for (int k = 0; k < 10; k++) dur[k] = (k % 2 == 0) ? 19 : 13;
    clear_q();
    send_frame(8'h6B, 1'b1);
    step(5);
    chk("skew_late_data", vld_d[0], 8'h6B);
    chk("skew_late_count", vld_t.size(), 1);

    chk("valid_err_overlap", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive end of the UART link: recovers 10-bit frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the `rx` line, which is the output of the team's transmitter. Valid bytes are presented on a parallel bus with a single-cycle strobe. The block runs on the system clock with an internal per-bit timer, so no external baud clock is needed. Stop-bit errors are reported on a separate strobe.

## Interface
- `CLKS_PER_BIT`, default 16: system clocks per serial bit; legal range ≥ 4; half-bit = `CLKS_PER_BIT/2`, rounded down.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset; one clock, synchronous, active-high.
- `rx`  input  1  asynchronous serial line; idles high.
- `rx_data`  output  8  last correctly framed byte; holds until the next good frame.
- `rx_valid`  output  1  one-cycle pulse; `rx_data` is new in this cycle.
- `frame_err`  output  1  one-cycle pulse; stop bit was sampled low.
- `busy`  output  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- FSM states:
  - IDLE: on `rxs`=0, load the bit timer with half-bit and go to START.
  - START: when the timer expires, sample `rxs` (mid start bit).
    - 1: false start; return to IDLE with no output.
    - 0: reload the timer with `CLKS_PER_BIT`, set bit index to 0, go to DATA.
  - DATA: on each timer expiry, shift `rxs` into bit `index` of the shift register (LSB first) and reload the timer. After index 7 is sampled, go to STOP.
  - STOP: on timer expiry, sample `rxs`.
    - 1: load the shift register into `rx_data`, pulse `rx_valid`, go to IDLE.
    - 0: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. A continuous low line produces exactly one `frame_err`.
- Returning to IDLE at the middle of the stop bit lets the next start edge be caught during a back-to-back frame.
- Counter widths:
  - Bit timer is `$clog2(CLKS_PER_BIT)` bits, counting down; it expires when it reaches 0.
  - Bit index is 3 bits. It is never compared past 7, and wrap-around is unused.
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, timer=0, index=0.
- `rst` asserted in any state, including mid-frame, takes effect on the next edge. The partial byte is discarded and no strobe is issued. After reset the synchronizer reads 1, so a line still low is not a start edge until it has gone high and then fallen again.

## Timing
- Let cycle E be the first edge at which the `rx` input is low.
  - `rxs` goes low at E+2.
  - Mid start-bit sample occurs at E+2+half.
  - Data bit i is sampled at E+2+half+(i+1)·`CLKS_PER_BIT`.
  - Stop-bit sample occurs at E+2+half+9·`CLKS_PER_BIT`.
- `rx_valid` / `frame_err` are registered: each is high for the one cycle after the stop sample. `rx_data` updates on that same edge.
- Total latency from start edge to `rx_valid` is 3+half+9·`CLKS_PER_BIT` cycles; this is 155 for `CLKS_PER_BIT`=16.
- `rx_valid` and `frame_err` are never high in the same cycle.
- `busy` goes high one cycle after `rxs` falls and drops on the same edge that raises `rx_valid`.
- There is no backpressure. The consumer must capture `rx_data` before the next frame completes, which is at least 9.5 bit times later.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - `DATA_BITS`=8;
  - `FRAME_BITS`=10, also used by the transmitter's frame counter.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1.
- Everything else (FSM, bit timer, index, shift register, output registers) lives in `uart_receiver`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Frame 0x55 with ideal timing: one `rx_valid` pulse at E+155 with `rx_data`=0x55; `frame_err` stays 0; `busy` is high from E+3 to E+154.
- Back-to-back frames 0xA3 then 0x0F with no idle gap: two `rx_valid` pulses exactly 160 cycles apart, carrying 0xA3 then 0x0F.
- Glitch (`rx` low for 4 cycles, then high): no strobe; `busy` is high briefly and returns to 0 by E+11; a following frame 0x3C is received correctly.
- Frame 0x81 with the stop bit held low for 40 cycles: one `frame_err` pulse at E+155; `rx_valid` stays 0; `rx_data` keeps its previous value; `busy` stays high until `rxs` returns to 1.
- `rst` asserted for one cycle during data bit 3 of 0xFF: all outputs are 0 on the next edge and no strobe follows; the next frame 0x12 gives `rx_data`=0x12.
- Bit-timing margin: a 0x6B frame with bit edges skewed ±3 clocks is still received as 0x6B.
